unsigned_restore_div_16x8: RTL and testbench

UNSIGNED_RESTORE_DIV_16X8 -- requirements
Module: unsigned_restore_div_16x8

---
 rtl/unsigned_restore_div_16x8_if.sv | 13 +
 rtl/unsigned_restore_div_16x8.sv | 76 +++++++
 tb/tb_unsigned_restore_div_16x8.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/unsigned_restore_div_16x8_if.sv
// unsigned_restore_div_16x8_if: request/result bundle for the 16/8 restoring divider.
interface unsigned_restore_div_16x8_if;
    logic        start;
    logic [15:0] z;
    logic [7:0]  y;
    logic        busy;
    logic        done;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ovf;
    modport master (output start, z, y, input busy, done, q, r, ovf);
    modport slave (input start, z, y, output busy, done, q, r, ovf);
endinterface

// File: rtl/unsigned_restore_div_16x8.sv
// unsigned_restore_div_16x8: 16/8 unsigned restoring divider, one quotient bit per cycle.
// DIV_APPROX_L4_EN: clear dividend bits [3:0] at latch time.
module unsigned_restore_div_16x8 (
    input logic clk,
    input logic rst,
    unsigned_restore_div_16x8_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      state, state_nx;
    logic [15:0] zm;
    logic        ovf_in, accept, neg;
    logic [7:0]  rem, dq, y_l, sub, rem_nx, dq_nx, q_reg, r_reg;
    logic        ovf_reg;
    logic [8:0]  p;
    logic [2:0]  cnt;
`ifdef DIV_APPROX_L4_EN
    assign zm = {bus.z[15:4], 4'h0};
`else
    assign zm = bus.z;
`endif
    // quotient fits in 8 bits only when the upper byte is below the divisor
    assign ovf_in = (bus.y == 8'd0) || (zm[15:8] >= bus.y);
    assign accept = bus.start && (state != CALC);
    assign p = {rem, dq[7]};
    assign neg = p < {1'b0, y_l};
    assign sub = p[7:0] - y_l;
    assign rem_nx = neg ? p[7:0] : sub;
    assign dq_nx = {dq[6:0], ~neg};
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = accept ? (ovf_in ? DONE : CALC)
                 : (state == CALC) ? ((cnt == 3'd7) ? DONE : CALC)
                 : IDLE;
    end
    always_comb begin
        bus.busy = state == CALC;
        bus.done = state == DONE;
    end
    // rem/dq form one shifting {remainder, dividend->quotient} pair
    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= 8'd0;
            dq <= 8'd0;
            y_l <= 8'd0;
            cnt <= 3'd0;
            q_reg <= 8'd0;
            r_reg <= 8'd0;
            ovf_reg <= 1'b0;
        end else if (accept) begin
            rem <= zm[15:8];
            dq <= zm[7:0];
            y_l <= bus.y;
            cnt <= 3'd0;
            if (ovf_in) begin
                q_reg <= 8'hFF;
                r_reg <= 8'h00;
                ovf_reg <= 1'b1;
            end
        end else if (state == CALC) begin
            rem <= rem_nx;
            dq <= dq_nx;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
                q_reg <= dq_nx;
                r_reg <= rem_nx;
                ovf_reg <= 1'b0;
            end
        end
    end
    assign bus.q = q_reg;
    assign bus.r = r_reg;
    assign bus.ovf = ovf_reg;
endmodule

// File: tb/tb_unsigned_restore_div_16x8.sv
// tb_unsigned_restore_div_16x8: vector table, handshake corner cases and random sweep
// against an arithmetic divide/modulo reference.
module tb_unsigned_restore_div_16x8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    unsigned_restore_div_16x8_if bus ();
    unsigned_restore_div_16x8 dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    typedef struct {
        int z;
        int y;
        int q;
        int r;
        int ovf;
    } vec_t;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic void model(input int z, input int y, output int q, output int r, output int o);
        int zm;
        zm = z;
`ifdef DIV_APPROX_L4_EN
        zm = zm & 32'hFFF0;
`endif
        o = (y == 0 || zm / y > 255) ? 1 : 0;
        q = o ? 255 : zm / y;
        r = o ? 0 : zm % y;
    endfunction

    task automatic start_op(input int z, input int y);
        bus.z = z[15:0];
        bus.y = y[7:0];
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_gap);
        lat = 0;
        busy_gap = 0;
        while (!bus.done && lat < 20) begin
            if (!bus.busy) busy_gap = 1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string name, input int z, input int y);
        int eq, er, eo, lat, gap;
        model(z, y, eq, er, eo);
        start_op(z, y);
        wait_done(lat, gap);
        check({name, " done_seen"}, int'(bus.done), 1);
        check({name, " latency"}, lat, eo ? 0 : 8);
        check({name, " busy_during_calc"}, gap, 0);
        check({name, " busy_at_done"}, int'(bus.busy), 0);
        check({name, " q"}, int'(bus.q), eq);
        check({name, " r"}, int'(bus.r), er);
        check({name, " ovf"}, int'(bus.ovf), eo);
        @(posedge clk); #1;
        check({name, " done_one_cycle"}, int'(bus.done), 0);
    endtask

    task automatic check_quiet(input string name);
        int seen;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen = 1;
        end
        check(name, seen, 0);
    endtask

    initial begin
        vec_t vt[8];
        int eq, er, eo, lat, gap;
        vt[0] = '{45400, 227, 200, 0, 0};
        vt[1] = '{1000, 7, 142, 6, 0};
        vt[2] = '{16'h0800, 8, 255, 0, 1};
        vt[3] = '{5, 0, 255, 0, 1};
        vt[4] = '{65025, 255, 255, 0, 0};
        vt[5] = '{100, 10, 10, 0, 0};
        vt[6] = '{16'h00FF, 1, 255, 0, 0};
        vt[7] = '{16'hFEFF, 255, 255, 254, 0};
`ifdef DIV_APPROX_L4_EN
        vt[0] = '{45400, 227, 199, 219, 0};
        vt[1] = '{1000, 7, 141, 5, 0};
        vt[4] = '{65025, 255, 254, 254, 0};
        vt[5] = '{100, 10, 9, 6, 0};
        vt[6] = '{16'h00FF, 1, 240, 0, 0};
        vt[7] = '{16'hFEFF, 255, 255, 239, 0};
`endif
        bus.start = 1'b0;
        bus.z = '0;
        bus.y = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        check("reset q", int'(bus.q), 0);
        check("reset r", int'(bus.r), 0);
        check("reset ovf", int'(bus.ovf), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            int lt;
            start_op(vt[i].z, vt[i].y);
            wait_done(lt, gap);
            check($sformatf("vec%0d latency", i), lt, vt[i].ovf ? 0 : 8);
            check($sformatf("vec%0d q", i), int'(bus.q), vt[i].q);
            check($sformatf("vec%0d r", i), int'(bus.r), vt[i].r);
            check($sformatf("vec%0d ovf", i), int'(bus.ovf), vt[i].ovf);
            @(posedge clk); #1;
            check($sformatf("vec%0d done_one_cycle", i), int'(bus.done), 0);
        end

        // starts and operand changes while busy must be ignored
        model(45400, 227, eq, er, eo);
        start_op(45400, 227);
        lat = 0;
        while (!bus.done && lat < 20) begin
            bus.start = (lat >= 1 && lat <= 5);
            bus.z = 16'd1000;
            bus.y = 8'd7;
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        check("ignore latency", lat, 8);
        check("ignore q", int'(bus.q), eq);
        check("ignore r", int'(bus.r), er);
        check_quiet("ignore no_restart");

        // reset in the middle of a calculation aborts it
        start_op(45400, 227);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", int'(bus.busy), 0);
        check("abort done", int'(bus.done), 0);
        check("abort q", int'(bus.q), 0);
        check("abort r", int'(bus.r), 0);
        check("abort ovf", int'(bus.ovf), 0);
        check_quiet("abort no_done");

        // reset beats a simultaneous start
        run_op("pre_rst", 1000, 7);
        rst = 1'b1;
        bus.start = 1'b1;
        bus.z = 16'd1000;
        bus.y = 8'd7;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.start = 1'b0;
        check("rst_start busy", int'(bus.busy), 0);
        check("rst_start q", int'(bus.q), 0);
        check_quiet("rst_start no_done");

        // back-to-back start in the done cycle
        model(1000, 7, eq, er, eo);
        start_op(1000, 7);
        wait_done(lat, gap);
        check("b2b first done", int'(bus.done), 1);
        bus.start = 1'b1;
        bus.z = 16'd65025;
        bus.y = 8'd255;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("b2b busy", int'(bus.busy), 1);
        check("b2b q_held", int'(bus.q), eq);
        check("b2b r_held", int'(bus.r), er);
        model(65025, 255, eq, er, eo);
        wait_done(lat, gap);
        check("b2b latency", lat + 1, 9);
        check("b2b q", int'(bus.q), eq);
        check("b2b r", int'(bus.r), er);
        @(posedge clk); #1;

        for (int i = 0; i < 3000; i++) begin
            int ry, rz;
            ry = int'($urandom_range(0, 255));
            if (($urandom % 2) == 1 && ry != 0) rz = int'($urandom_range(0, ry * 256 - 1));
            else rz = int'($urandom_range(0, 65535));
            run_op($sformatf("rand%0d z=%0d y=%0d", i, rz, ry), rz, ry);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
